// File: rtl/mem_responder.sv
// mem_responder: memory-side responder for the CPU memory port.
// Serialises one request at a time through IDLE -> WAIT -> RESP. The wait
// counter models slow memory. The backing word RAM has byte-lane write strobes.
module mem_responder #(
    parameter int unsigned DEPTH   = 1024,
    parameter int unsigned LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    input  logic        ren,
    input  logic        wen,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        err
);

    localparam int unsigned AW    = $clog2(DEPTH);
    localparam logic [3:0]  LAT_C = 4'(LATENCY);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;

    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  wstrb_q;
    logic        ren_q;
    logic        wen_q;

    logic        ready_q;
    logic        err_q;
    logic [31:0] rdata_q;

    logic        cap_c;
    logic        enter_resp_c;

    logic [31:0] eff_addr_c;
    logic [31:0] eff_wdata_c;
    logic [3:0]  eff_wstrb_c;
    logic        eff_ren_c;
    logic        eff_wen_c;
    logic        err_c;
    logic        do_read_c;
    logic        do_write_c;
    logic [AW-1:0] idx_c;

    logic [31:0] mem [DEPTH];

    // State and wait-counter registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state, counter and strobe decode
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        cap_c        = 1'b0;
        enter_resp_c = 1'b0;
        case (state_q)
            IDLE: begin
                if (ren || wen) begin
                    cap_c = 1'b1;
                    cnt_d = LAT_C;
                    if (LAT_C == 4'd0) begin
                        state_d      = RESP;
                        enter_resp_c = 1'b1;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d      = RESP;
                    enter_resp_c = 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // Request latch, captured only when a request is accepted in IDLE
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            wstrb_q <= 4'd0;
            ren_q   <= 1'b0;
            wen_q   <= 1'b0;
        end else if (cap_c) begin
            addr_q  <= addr;
            wdata_q <= wdata;
            wstrb_q <= wstrb;
            ren_q   <= ren;
            wen_q   <= wen;
        end
    end

    // Effective request: live inputs when entering RESP straight from IDLE
    // (zero latency), otherwise the latched copy
    always_comb begin
        if (state_q == IDLE) begin
            eff_addr_c  = addr;
            eff_wdata_c = wdata;
            eff_wstrb_c = wstrb;
            eff_ren_c   = ren;
            eff_wen_c   = wen;
        end else begin
            eff_addr_c  = addr_q;
            eff_wdata_c = wdata_q;
            eff_wstrb_c = wstrb_q;
            eff_ren_c   = ren_q;
            eff_wen_c   = wen_q;
        end
    end

    // Error classification and RAM access qualification
    always_comb begin
        err_c      = (eff_addr_c[1:0] != 2'b00)
                   || (|eff_addr_c[31:AW+2])
                   || (eff_ren_c && eff_wen_c);
        idx_c      = eff_addr_c[AW+1:2];
        do_read_c  = enter_resp_c && eff_ren_c && !eff_wen_c && !err_c;
        do_write_c = enter_resp_c && eff_wen_c && !eff_ren_c && !err_c;
    end

    // Byte-lane RAM write, committed on the edge entering RESP
    always_ff @(posedge clk) begin
        if (do_write_c) begin
            for (int i = 0; i < 4; i++) begin
                if (eff_wstrb_c[i]) begin
                    mem[idx_c][8*i +: 8] <= eff_wdata_c[8*i +: 8];
                end
            end
        end
    end

    // Registered response: live only for the single RESP cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= 32'd0;
        end else if (enter_resp_c) begin
            ready_q <= 1'b1;
            err_q   <= err_c;
            rdata_q <= do_read_c ? mem[idx_c] : 32'd0;
        end else begin
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= 32'd0;
        end
    end

    assign ready = ready_q;
    assign err   = err_q;
    assign rdata = rdata_q;

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: four instances at different latencies.
// The drivers push expected responses and a negedge monitor pops and compares them.
module tb_mem_responder;

    localparam int unsigned DEPTH = 64;

    typedef struct {
        int          inst;
        logic [31:0] rdata;
        logic        err;
        int          cyc;
        string       name;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_s   [4];
    logic [31:0] addr_s  [4];
    logic [31:0] wdata_s [4];
    logic [3:0]  wstrb_s [4];
    logic        ren_s   [4];
    logic        wen_s   [4];
    logic [31:0] rdata_s [4];
    logic        rdy_s   [4];
    logic        err_s   [4];

    exp_t sbq[$];
    int   cyc    = 0;
    int   n_cmp  = 0;
    int   n_bad  = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    mem_responder #(.DEPTH(DEPTH), .LATENCY(1)) u_lat1 (
        .clk(clk), .rst(rst_s[0]), .addr(addr_s[0]), .wdata(wdata_s[0]),
        .wstrb(wstrb_s[0]), .ren(ren_s[0]), .wen(wen_s[0]),
        .rdata(rdata_s[0]), .ready(rdy_s[0]), .err(err_s[0]));

    mem_responder #(.DEPTH(DEPTH), .LATENCY(0)) u_lat0 (
        .clk(clk), .rst(rst_s[1]), .addr(addr_s[1]), .wdata(wdata_s[1]),
        .wstrb(wstrb_s[1]), .ren(ren_s[1]), .wen(wen_s[1]),
        .rdata(rdata_s[1]), .ready(rdy_s[1]), .err(err_s[1]));

    mem_responder #(.DEPTH(DEPTH), .LATENCY(5)) u_lat5 (
        .clk(clk), .rst(rst_s[2]), .addr(addr_s[2]), .wdata(wdata_s[2]),
        .wstrb(wstrb_s[2]), .ren(ren_s[2]), .wen(wen_s[2]),
        .rdata(rdata_s[2]), .ready(rdy_s[2]), .err(err_s[2]));

    mem_responder #(.DEPTH(DEPTH), .LATENCY(4)) u_lat4 (
        .clk(clk), .rst(rst_s[3]), .addr(addr_s[3]), .wdata(wdata_s[3]),
        .wstrb(wstrb_s[3]), .ren(ren_s[3]), .wen(wen_s[3]),
        .rdata(rdata_s[3]), .ready(rdy_s[3]), .err(err_s[3]));

    function automatic int lat_of(input int k);
        case (k)
            0:       return 1;
            1:       return 0;
            2:       return 5;
            default: return 4;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Issue one request on instance k and queue its expected response
    task automatic issue(input int k, input string name, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] s,
                         input logic r, input logic w,
                         input logic [31:0] er, input logic ee);
        exp_t e;
        @(negedge clk);
        addr_s[k] = a; wdata_s[k] = d; wstrb_s[k] = s; ren_s[k] = r; wen_s[k] = w;
        e.inst = k; e.rdata = er; e.err = ee; e.cyc = cyc + 1 + lat_of(k); e.name = name;
        sbq.push_back(e);
        @(negedge clk);
        ren_s[k] = 1'b0; wen_s[k] = 1'b0;
        repeat (lat_of(k) + 1) @(negedge clk);
    endtask

    // Monitor: every negedge, match ready pulses against the scoreboard and
    // confirm outputs are quiet outside a response
    always @(negedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (rdy_s[k] === 1'b1) begin
                int idx;
                idx = -1;
                for (int j = 0; j < sbq.size(); j++) begin
                    if (sbq[j].inst == k) begin
                        idx = j;
                        break;
                    end
                end
                if (idx < 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_ready inst%0d: got ready=1 expected 0 at cyc %0d", k, cyc);
                end else begin
                    exp_t e;
                    e = sbq[idx];
                    sbq.delete(idx);
                    chk({e.name, "_rdata"}, rdata_s[k], e.rdata);
                    chk({e.name, "_err"}, 32'(err_s[k]), 32'(e.err));
                    chk({e.name, "_cycle"}, 32'(cyc), 32'(e.cyc));
                end
            end else begin
                chk($sformatf("quiet_inst%0d", k), rdata_s[k] | 32'(err_s[k]), 32'd0);
            end
        end
    end

    initial begin
        int n0;
        for (int k = 0; k < 4; k++) begin
            rst_s[k] = 1'b0; addr_s[k] = '0; wdata_s[k] = '0;
            wstrb_s[k] = '0; ren_s[k] = 1'b0; wen_s[k] = 1'b0;
        end
        #3;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("reset_ready%0d", k), 32'(rdy_s[k]), 32'd0);
            chk($sformatf("reset_err%0d", k), 32'(err_s[k]), 32'd0);
            chk($sformatf("reset_rdata%0d", k), rdata_s[k], 32'd0);
        end
        repeat (2) @(negedge clk);
        for (int k = 0; k < 4; k++) rst_s[k] = 1'b1;

        // LATENCY=1: full write/read, byte lanes, error cases
        issue(0, "wr_full",    32'h10, 32'hDEADBEEF, 4'hF, 1'b0, 1'b1, 32'h0, 1'b0);
        issue(0, "rd_full",    32'h10, 32'h0,        4'h0, 1'b1, 1'b0, 32'hDEADBEEF, 1'b0);
        issue(0, "wr_lanes",   32'h10, 32'h11223344, 4'b0101, 1'b0, 1'b1, 32'h0, 1'b0);
        issue(0, "rd_lanes",   32'h10, 32'h0,        4'h0, 1'b1, 1'b0, 32'hDE22BE44, 1'b0);
        issue(0, "wr_word0",   32'h0,  32'h55AA55AA, 4'hF, 1'b0, 1'b1, 32'h0, 1'b0);
        issue(0, "wr_oor",     DEPTH*4, 32'hFFFFFFFF, 4'hF, 1'b0, 1'b1, 32'h0, 1'b1);
        issue(0, "rd_word0",   32'h0,  32'h0,        4'h0, 1'b1, 1'b0, 32'h55AA55AA, 1'b0);
        issue(0, "rd_misalign",32'h13, 32'h0,        4'h0, 1'b1, 1'b0, 32'h0, 1'b1);
        issue(0, "rd_wr_both", 32'h10, 32'h99999999, 4'hF, 1'b1, 1'b1, 32'h0, 1'b1);
        issue(0, "wr_nostrb",  32'h10, 32'h77777777, 4'h0, 1'b0, 1'b1, 32'h0, 1'b0);
        issue(0, "rd_after",   32'h10, 32'h0,        4'h0, 1'b1, 1'b0, 32'hDE22BE44, 1'b0);

        // LATENCY=0: ready in the cycle after capture
        issue(1, "l0_wr", 32'h8, 32'h0BADF00D, 4'hF, 1'b0, 1'b1, 32'h0, 1'b0);
        issue(1, "l0_rd", 32'h8, 32'h0,        4'h0, 1'b1, 1'b0, 32'h0BADF00D, 1'b0);

        // LATENCY=5: held read repeats every LATENCY+2 cycles
        issue(2, "l5_wr", 32'h4, 32'hA5A5A5A5, 4'hF, 1'b0, 1'b1, 32'h0, 1'b0);
        @(negedge clk);
        addr_s[2] = 32'h4; ren_s[2] = 1'b1; wen_s[2] = 1'b0;
        n0 = cyc;
        for (int i = 0; i < 3; i++) begin
            exp_t e;
            e.inst = 2; e.rdata = 32'hA5A5A5A5; e.err = 1'b0;
            e.cyc = n0 + 6 + 7 * i; e.name = $sformatf("l5_hold%0d", i);
            sbq.push_back(e);
        end
        repeat (20) @(negedge clk);
        ren_s[2] = 1'b0;
        repeat (3) @(negedge clk);

        // LATENCY=4: reset during WAIT discards the write
        issue(3, "l4_prewr", 32'h20, 32'h0, 4'hF, 1'b0, 1'b1, 32'h0, 1'b0);
        @(negedge clk);
        addr_s[3] = 32'h20; wdata_s[3] = 32'hCAFEF00D; wstrb_s[3] = 4'hF;
        wen_s[3] = 1'b1;
        @(negedge clk);
        wen_s[3] = 1'b0;
        @(negedge clk);
        rst_s[3] = 1'b0;
        repeat (3) @(negedge clk);
        rst_s[3] = 1'b1;
        repeat (6) @(negedge clk);
        issue(3, "l4_rd_after_rst", 32'h20, 32'h0, 4'h0, 1'b1, 1'b0, 32'h0, 1'b0);

        // LATENCY=1: reset during RESP clears outputs asynchronously
        @(negedge clk);
        addr_s[0] = 32'h10; ren_s[0] = 1'b1;
        @(negedge clk);
        ren_s[0] = 1'b0;
        @(posedge clk);
        #1;
        chk("resp_rst_pre_ready", 32'(rdy_s[0]), 32'd1);
        chk("resp_rst_pre_rdata", rdata_s[0], 32'hDE22BE44);
        #1 rst_s[0] = 1'b0;
        #1;
        chk("resp_rst_ready", 32'(rdy_s[0]), 32'd0);
        chk("resp_rst_err",   32'(err_s[0]), 32'd0);
        chk("resp_rst_rdata", rdata_s[0], 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_s[0] = 1'b1;
        issue(0, "rd_post_rst", 32'h10, 32'h0, 4'h0, 1'b1, 1'b0, 32'hDE22BE44, 1'b0);

        // Drain, with a bound on outstanding responses
        for (int i = 0; i < 50 && sbq.size() != 0; i++) @(negedge clk);
        while (sbq.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL missing_ready %s: got no response expected one at cyc %0d",
                     sbq[0].name, sbq[0].cyc);
            void'(sbq.pop_front());
        end
        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
